// File: rtl/r_sdpram_be.sv
// rtl/r_sdpram_be.sv - simple-dual-port RAM with lane write enables, bypass, 1/2-cycle read latency and zero-clear sweep
module r_sdpram_be #(
    parameter int AW         = 8,
    parameter int DW         = 18,
    parameter int LANES      = 2,
    parameter int RD_LAT     = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [AW-1:0]    WA,
    input  logic [DW-1:0]    WD,
    input  logic [LANES-1:0] WEN,
    input  logic             WD_SEL,
    input  logic [AW-1:0]    RA,
    input  logic             RD_SEL,
    output logic [DW-1:0]    RD,
    output logic             RD_Valid,
    output logic             Init_Busy
);

    localparam int LW = DW / LANES;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

    if (DW % LANES != 0) begin : g_bad_lanes
        $fatal(1, "r_sdpram_be: DW must be divisible by LANES");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $fatal(1, "r_sdpram_be: RD_LAT must be 1 or 2");
    end

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] lane_mask;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] rd_old;
    logic [DW-1:0] rd_word;
    logic          run;
    logic          wr_en;
    logic          rd_req;

    assign run       = Rst_n && (state == ST_RUN);
    assign wr_en     = run && WD_SEL && (|WEN);
    assign rd_req    = run && RD_SEL;
    assign Init_Busy = (state == ST_CLEAR);

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i*LW +: LW] = {LW{WEN[i]}};
        end
    end

    assign rd_old  = mem[RA];
    assign wr_word = (mem[WA] & ~lane_mask) | (WD & lane_mask);

    // Same-address bypass merges only the enabled lanes; the rest stay old.
    always_comb begin
        rd_word = rd_old;
        if (BYPASS != 0 && wr_en && (WA == RA)) begin
            rd_word = (rd_old & ~lane_mask) | (WD & lane_mask);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= ST_RESET;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt) begin
                state <= ST_RUN;
            end
        end
    end

    // Array has no reset; the clear sweep is the only way it gets zeroed.
    always_ff @(posedge Clk) begin
        if (Rst_n && (state == ST_CLEAR)) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[WA] <= wr_word;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DW-1:0] p1_data;
        logic          p1_vld;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                p1_data  <= '0;
                p1_vld   <= 1'b0;
                RD       <= '0;
                RD_Valid <= 1'b0;
            end else begin
                p1_vld   <= rd_req;
                RD_Valid <= p1_vld;
                if (rd_req) begin
                    p1_data <= rd_word;
                end
                if (p1_vld) begin
                    RD <= p1_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                RD       <= '0;
                RD_Valid <= 1'b0;
            end else begin
                RD_Valid <= rd_req;
                if (rd_req) begin
                    RD <= rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_r_sdpram_be.sv
// tb/tb_r_sdpram_be.sv - scoreboard bench for r_sdpram_be across bypass, latency and clear variants
module tb_r_sdpram_be;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst_n;
    logic [7:0]  wa, ra;
    logic [17:0] wd;
    logic [1:0]  wen;
    logic        wd_sel, rd_sel;
    logic [2:0][17:0] rd_d;
    logic [2:0]  rd_v, busy;

    logic [3:0]  b_wa, b_ra;
    logic [31:0] b_wd, b_rd;
    logic [3:0]  b_wen;
    logic        b_wsel, b_rsel, b_v, b_busy;

    r_sdpram_be #(.BYPASS(1), .RD_LAT(1)) u_b1l1 (
        .Clk(Clk), .Rst_n(rst_n), .WA(wa), .WD(wd), .WEN(wen), .WD_SEL(wd_sel),
        .RA(ra), .RD_SEL(rd_sel), .RD(rd_d[0]), .RD_Valid(rd_v[0]), .Init_Busy(busy[0]));
    r_sdpram_be #(.BYPASS(0), .RD_LAT(1)) u_b0l1 (
        .Clk(Clk), .Rst_n(rst_n), .WA(wa), .WD(wd), .WEN(wen), .WD_SEL(wd_sel),
        .RA(ra), .RD_SEL(rd_sel), .RD(rd_d[1]), .RD_Valid(rd_v[1]), .Init_Busy(busy[1]));
    r_sdpram_be #(.BYPASS(1), .RD_LAT(2)) u_b1l2 (
        .Clk(Clk), .Rst_n(rst_n), .WA(wa), .WD(wd), .WEN(wen), .WD_SEL(wd_sel),
        .RA(ra), .RD_SEL(rd_sel), .RD(rd_d[2]), .RD_Valid(rd_v[2]), .Init_Busy(busy[2]));
    r_sdpram_be #(.AW(4), .DW(32), .LANES(4), .INIT_CLEAR(0)) u_wide (
        .Clk(Clk), .Rst_n(rst_n), .WA(b_wa), .WD(b_wd), .WEN(b_wen), .WD_SEL(b_wsel),
        .RA(b_ra), .RD_SEL(b_rsel), .RD(b_rd), .RD_Valid(b_v), .Init_Busy(b_busy));

    typedef struct {
        int          due;
        logic [17:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]  wa;
        logic [17:0] wd;
        logic [1:0]  wen;
        logic        wsel;
        logic [7:0]  ra;
        logic        rsel;
        logic [17:0] exp_b1;
        logic [17:0] exp_b0;
    } vec_t;

    exp_t        sb [3][$];
    vec_t        vt [20];
    logic [17:0] mdl [256];
    logic [17:0] exp_rd [3];
    logic [17:0] tb_e1, tb_e0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          clr_left = 256;
    int          n;
    bit          mon_en = 0;
    bit          use_tbl = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [17:0] lmask(input logic [1:0] w);
        return {{9{w[1]}}, {9{w[0]}}};
    endfunction

    // Advance one clock; the model consumes the inputs held across this edge.
    task automatic tick();
        logic [17:0] old_w, m, byp;
        exp_t e;
        @(posedge Clk);
        if (rst_n) begin
            if (clr_left > 0) begin
                clr_left--;
            end else begin
                m = lmask(wen);
                if (rd_sel) begin
                    old_w = mdl[ra];
                    byp = (wd_sel && wen != 2'b00 && wa == ra) ? ((old_w & ~m) | (wd & m)) : old_w;
                    if (use_tbl) begin
                        byp   = tb_e1;
                        old_w = tb_e0;
                    end
                    e.due = cyc + 1; e.data = byp;   sb[0].push_back(e);
                    e.due = cyc + 1; e.data = old_w; sb[1].push_back(e);
                    e.due = cyc + 2; e.data = byp;   sb[2].push_back(e);
                end
                if (wd_sel && wen != 2'b00) mdl[wa] = (mdl[wa] & ~m) | (wd & m);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        wd_sel = 0; rd_sel = 0; wa = 0; ra = 0; wd = 0; wen = 0;
    endtask

    task automatic pulse_reset(input int cycles);
        rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            sb[k].delete();
            exp_rd[k] = '0;
        end
        for (int a = 0; a < 256; a++) mdl[a] = '0;
        clr_left = 256;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_rd%0d", k), rd_d[k], 0);
            check($sformatf("rst_valid%0d", k), rd_v[k], 0);
        end
        repeat (cycles) tick();
        rst_n = 1;
    endtask

    task automatic measure_busy(output int len);
        len = 0;
        while (busy[0] && len < 1000) begin
            tick();
            len++;
        end
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                exp_t e;
                logic exp_v;
                check($sformatf("busy%0d", k), busy[k], clr_left > 0);
                exp_v = (sb[k].size() > 0) && (sb[k][0].due == cyc);
                check($sformatf("valid%0d", k), rd_v[k], exp_v);
                if (exp_v) begin
                    e = sb[k].pop_front();
                    exp_rd[k] = e.data;
                end
                check($sformatf("rd%0d", k), rd_d[k], exp_rd[k]);
            end
        end
    end

    initial begin
        vt[0]  = '{8'h12, 18'h3FFFF, 2'b01, 1'b1, 8'h00, 1'b0, 18'h00000, 18'h00000};
        vt[1]  = '{8'h12, 18'h00000, 2'b10, 1'b1, 8'h00, 1'b0, 18'h00000, 18'h00000};
        vt[2]  = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h12, 1'b1, 18'h001FF, 18'h001FF};
        vt[3]  = '{8'h40, 18'h15555, 2'b11, 1'b1, 8'h00, 1'b0, 18'h00000, 18'h00000};
        vt[4]  = '{8'h40, 18'h2AAAA, 2'b10, 1'b1, 8'h40, 1'b1, 18'h2AB55, 18'h15555};
        vt[5]  = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h40, 1'b1, 18'h2AB55, 18'h2AB55};
        vt[6]  = '{8'h01, 18'h00011, 2'b11, 1'b1, 8'h00, 1'b0, 18'h00000, 18'h00000};
        vt[7]  = '{8'h02, 18'h00022, 2'b11, 1'b1, 8'h00, 1'b0, 18'h00000, 18'h00000};
        vt[8]  = '{8'h03, 18'h00033, 2'b11, 1'b1, 8'h00, 1'b0, 18'h00000, 18'h00000};
        vt[9]  = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h01, 1'b1, 18'h00011, 18'h00011};
        vt[10] = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h02, 1'b1, 18'h00022, 18'h00022};
        vt[11] = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h03, 1'b1, 18'h00033, 18'h00033};
        vt[12] = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h00, 1'b0, 18'h00000, 18'h00000};
        vt[13] = '{8'h03, 18'h3FFFF, 2'b11, 1'b1, 8'h03, 1'b1, 18'h3FFFF, 18'h00033};
        vt[14] = '{8'h03, 18'h00000, 2'b11, 1'b1, 8'h00, 1'b0, 18'h00000, 18'h00000};
        vt[15] = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h03, 1'b1, 18'h00000, 18'h00000};
        vt[16] = '{8'h05, 18'h3FFFF, 2'b11, 1'b0, 8'h05, 1'b1, 18'h00000, 18'h00000};
        vt[17] = '{8'h06, 18'h3FFFF, 2'b00, 1'b1, 8'h06, 1'b1, 18'h00000, 18'h00000};
        vt[18] = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h05, 1'b1, 18'h00000, 18'h00000};
        vt[19] = '{8'h00, 18'h00000, 2'b00, 1'b0, 8'h06, 1'b1, 18'h00000, 18'h00000};

        rst_n = 0;
        idle();
        b_wa = 0; b_ra = 0; b_wd = 0; b_wen = 0; b_wsel = 0; b_rsel = 0;
        tb_e1 = 0; tb_e0 = 0;
        for (int k = 0; k < 3; k++) exp_rd[k] = '0;
        for (int a = 0; a < 256; a++) mdl[a] = '0;
        tick();
        tick();
        mon_en = 1;
        check("wide_busy_rst", b_busy, 0);
        rst_n = 1;

        // Sweep: reads requested throughout must be ignored; wide instance runs meanwhile.
        rd_sel = 1; ra = 8'hFF; n = 0;
        while (busy[0] && n < 1000) begin
            b_wsel = 0; b_rsel = 0;
            case (n)
                0: begin b_wa = 4'h0; b_wd = 32'h0; b_wen = 4'hF; b_wsel = 1; end
                1: begin b_wa = 4'h0; b_wd = 32'hDEADBEEF; b_wen = 4'b1010; b_wsel = 1; end
                2: begin b_ra = 4'h0; b_rsel = 1; end
                default: ;
            endcase
            tick();
            n++;
            if (n == 1) check("wide_busy_run", b_busy, 0);
            if (n == 3) begin
                check("wide_valid", b_v, 1);
                check("wide_rd", b_rd, 32'hDE00BE00);
            end
            if (n == 4) begin
                check("wide_valid_drop", b_v, 0);
                check("wide_rd_hold", b_rd, 32'hDE00BE00);
            end
        end
        check("busy_len", n, 256);
        tick();
        idle();
        repeat (3) tick();

        use_tbl = 1;
        for (int i = 0; i < 20; i++) begin
            wa = vt[i].wa; wd = vt[i].wd; wen = vt[i].wen; wd_sel = vt[i].wsel;
            ra = vt[i].ra; rd_sel = vt[i].rsel;
            tb_e1 = vt[i].exp_b1; tb_e0 = vt[i].exp_b0;
            tick();
        end
        use_tbl = 0;
        idle();
        repeat (3) tick();

        repeat (300) begin
            wa = 8'($urandom_range(0, 7)); ra = 8'($urandom_range(0, 7));
            wd = 18'($urandom); wen = 2'($urandom_range(0, 3));
            wd_sel = 1'($urandom_range(0, 1)); rd_sel = 1'($urandom_range(0, 1));
            tick();
        end
        idle();
        repeat (3) tick();

        // Reset while a read is in flight, then again part-way through the sweep.
        wa = 8'h80; wd = 18'h1ABCD; wen = 2'b11; wd_sel = 1;
        tick();
        idle();
        ra = 8'h80; rd_sel = 1;
        tick();
        rd_sel = 0;
        check("pre_rst_rd", rd_d[0], 18'h1ABCD);
        pulse_reset(1);
        repeat (100) tick();
        pulse_reset(1);
        rd_sel = 1; ra = 8'h80;
        measure_busy(n);
        check("busy_len_rst", n, 256);
        tick();
        idle();
        repeat (4) tick();

        for (int k = 0; k < 3; k++) check($sformatf("sb_empty%0d", k), sb[k].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
